// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared operand types, feeder states and width helpers for the NPU datapath
package npu_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DRAIN
  } feed_state_e;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - operand beat handshake plus the skewed row/column lanes into the array
interface systolic_feeder_if #(
  parameter int N = 2
);

  logic                      in_valid;
  logic                      in_ready;
  npu_pkg::operand_t [N-1:0] in_a_col;
  npu_pkg::operand_t [N-1:0] in_b_row;
  npu_pkg::operand_t [N-1:0] A_out;
  npu_pkg::operand_t [N-1:0] B_out;
  logic                      streaming;
  logic                      done;

  modport feeder (
    input  in_valid,
    input  in_a_col,
    input  in_b_row,
    output in_ready,
    output A_out,
    output B_out,
    output streaming,
    output done
  );

  modport host (
    output in_valid,
    output in_a_col,
    output in_b_row,
    input  in_ready,
    input  A_out,
    input  B_out,
    input  streaming,
    input  done
  );

endinterface

// File: rtl/systolic_feeder_skew_lane.sv
// rtl/systolic_feeder_skew_lane.sv - picks one lane's operand for slot t on the skew diagonal, zero elsewhere
module skew_lane
  import npu_pkg::*;
#(
  parameter int N         = 2,
  parameter int T_W       = 2,
  parameter int LANE      = 0,
  parameter bit ROW_MAJOR = 1'b1
) (
  input  operand_t [N-1:0][N-1:0] mem,
  input  logic [T_W-1:0]          t,
  output operand_t                data
);

  // Element k reaches this lane at slot k+LANE; ROW_MAJOR picks mem[lane][k] (A) vs mem[k][lane] (B).
  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(t) == k + LANE) begin
        data = ROW_MAJOR ? mem[LANE][k] : mem[k][LANE];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers one N-beat operand block and replays it diagonally skewed into the array
module systolic_feeder
  import npu_pkg::*;
#(
  parameter int N            = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  systolic_feeder_if.feeder bus
);

  localparam int T_W  = $clog2(2 * N);
  localparam int BC_W = cnt_w(N);
  localparam int D_W  = cnt_w(DRAIN_CYCLES);

  localparam logic [T_W-1:0]  T_LAST  = T_W'(2 * N - 2);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(N - 1);
  localparam logic [D_W-1:0]  D_LAST  = D_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  feed_state_e               state, state_n;
  logic [BC_W-1:0]           beat_cnt, beat_n;
  logic [T_W-1:0]            t, t_n;
  logic [D_W-1:0]            drain_cnt, drain_n;
  logic                      done_n;
  logic                      accept;
  logic                      ready_q, streaming_q, done_q;
  operand_t [N-1:0][N-1:0]   a_mem, a_mem_n;
  operand_t [N-1:0][N-1:0]   b_mem, b_mem_n;
  operand_t [N-1:0]          lane_a, lane_b;
  operand_t [N-1:0]          a_q, b_q;

  assign accept = bus.in_valid & ready_q;

  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    t_n     = t;
    drain_n = drain_cnt;
    done_n  = 1'b0;
    a_mem_n = a_mem;
    b_mem_n = b_mem;
    if (flush) begin
      state_n = LOAD;
      beat_n  = '0;
      t_n     = '0;
      drain_n = '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            // A is kept row-major (A[i][k]), B as delivered (B[k][j]).
            for (int k = 0; k < N; k++) begin
              if (beat_cnt == BC_W'(k)) begin
                for (int i = 0; i < N; i++) begin
                  a_mem_n[i][k] = bus.in_a_col[i];
                end
                b_mem_n[k] = bus.in_b_row;
              end
            end
            if (beat_cnt == BC_LAST) begin
              state_n = STREAM;
              beat_n  = '0;
              t_n     = '0;
            end else begin
              beat_n = beat_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (t == T_LAST) begin
            t_n     = '0;
            drain_n = '0;
            if (DRAIN_CYCLES == 0) begin
              state_n = LOAD;
              done_n  = 1'b1;
            end else begin
              state_n = DRAIN;
            end
          end else begin
            t_n = t + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state_n = LOAD;
            drain_n = '0;
            done_n  = 1'b1;
          end else begin
            drain_n = drain_cnt + 1'b1;
          end
        end
        default: state_n = LOAD;
      endcase
    end
  end

  // Lanes look at the next-cycle buffer and slot so the registered outputs line up with state.
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane #(.N(N), .T_W(T_W), .LANE(g), .ROW_MAJOR(1'b1)) u_a (
      .mem  (a_mem_n),
      .t    (t_n),
      .data (lane_a[g])
    );
    skew_lane #(.N(N), .T_W(T_W), .LANE(g), .ROW_MAJOR(1'b0)) u_b (
      .mem  (b_mem_n),
      .t    (t_n),
      .data (lane_b[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      beat_cnt    <= '0;
      t           <= '0;
      drain_cnt   <= '0;
      ready_q     <= 1'b1;
      streaming_q <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state       <= state_n;
      beat_cnt    <= beat_n;
      t           <= t_n;
      drain_cnt   <= drain_n;
      ready_q     <= (state_n == LOAD);
      streaming_q <= (state_n == STREAM);
      done_q      <= done_n;
      a_q         <= (state_n == STREAM) ? lane_a : '0;
      b_q         <= (state_n == STREAM) ? lane_b : '0;
    end
  end

  // Operand storage carries no reset: contents are only read after a full block is loaded.
  always_ff @(posedge clk) begin
    a_mem <= a_mem_n;
    b_mem <= b_mem_n;
  end

  assign bus.in_ready  = ready_q;
  assign bus.streaming = streaming_q;
  assign bus.done      = done_q;
  assign bus.A_out     = a_q;
  assign bus.B_out     = b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard plus table-driven block checks for systolic_feeder
module tb_systolic_feeder;
  import npu_pkg::*;

  localparam int DC = 4;

  typedef struct packed { logic [15:0] a; logic [15:0] b; } slot_t;
  typedef struct { operand_t a [2][2]; operand_t b [2][2]; acc_t c [2][2]; } vec_t;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic flush  = 1'b0;
  logic flush4 = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(2)) bus ();
  systolic_feeder_if #(.N(4)) bus4 ();

  systolic_feeder #(.N(2), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.feeder));
  systolic_feeder #(.N(4), .DRAIN_CYCLES(0)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .bus(bus4.feeder));

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_stream = 0;
  int hlen = 0;
  slot_t exp_q [$];
  slot_t mon_s;
  logic [31:0] ha [128];
  logic [31:0] hb [128];
  logic [31:0] ha4 [128];
  logic [31:0] hb4 [128];
  acc_t c_model [2][2];
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output-stationary array: PE(i,j) sees lane-A i delayed by j and lane-B j delayed by i.
  function automatic int arr_c(input bit big, input int i, input int j, input int len);
    int acc = 0;
    for (int c = 0; c < len; c++) begin
      if (c >= i && c >= j) begin
        if (big) acc += int'(ha4[c-j][i*8 +: 8]) * int'(hb4[c-i][j*8 +: 8]);
        else     acc += int'(ha[c-j][i*8 +: 8]) * int'(hb[c-i][j*8 +: 8]);
      end
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      hlen = 0;
    end else begin
      cyc++;
      if (hlen < 128) begin
        ha[hlen] = 32'(bus.A_out);
        hb[hlen] = 32'(bus.B_out);
        hlen++;
      end
      if (bus.streaming) begin
        last_stream = cyc;
        check("ready_low_in_stream", 64'(bus.in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stream: slot a=%h b=%h with none expected", bus.A_out, bus.B_out);
        end else begin
          mon_s = exp_q.pop_front();
          check("a_out", 64'(bus.A_out), 64'(mon_s.a));
          check("b_out", 64'(bus.B_out), 64'(mon_s.b));
        end
      end else begin
        check("idle_zero", 64'({bus.A_out, bus.B_out}), 64'd0);
      end
      if (bus.done) begin
        done_cnt++;
        check("done_latency", 64'(cyc - last_stream), 64'(DC + 1));
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            c_model[i][j] = acc_t'(arr_c(1'b0, i, j, hlen));
        hlen = 0;
      end
      if (flush) begin
        exp_q.delete();
        hlen = 0;
      end
    end
  end

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a_col = a;
    bus.in_b_row = b;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready low for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic load_block(input vec_t v, input bit keep, input int gap);
    slot_t s;
    for (int t = 0; t < 3; t++) begin
      s = '0;
      for (int i = 0; i < 2; i++) begin
        if (t - i >= 0 && t - i < 2) begin
          s.a[i*8 +: 8] = v.a[i][t-i];
          s.b[i*8 +: 8] = v.b[t-i][i];
        end
      end
      exp_q.push_back(s);
    end
    for (int k = 0; k < 2; k++) begin
      send_beat({v.a[1][k], v.a[0][k]}, {v.b[k][1], v.b[k][0]});
      if (k == 0 && gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        check("gap_no_stream", 64'(bus.streaming), 64'd0);
      end
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic check_c(input vec_t v, input string tag);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), 64'(c_model[i][j]), 64'(v.c[i][j]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int s_cnt;
    int first_nz;
    int done_idx;
    operand_t a4 [4][4];

    bus.in_valid  = 1'b0;
    bus.in_a_col  = '0;
    bus.in_b_row  = '0;
    bus4.in_valid = 1'b0;
    bus4.in_a_col = '0;
    bus4.in_b_row = '0;

    vecs[0].a = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
    vecs[0].b = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}};
    vecs[0].c = '{'{16'd19, 16'd22}, '{16'd43, 16'd50}};
    vecs[1].a = '{'{8'd255, 8'd0}, '{8'd0, 8'd255}};
    vecs[1].b = '{'{8'd255, 8'd1}, '{8'd2, 8'd255}};
    vecs[1].c = '{'{16'd65025, 16'd255}, '{16'd510, 16'd65025}};
    vecs[2].a = '{'{8'd0, 8'd0}, '{8'd0, 8'd0}};
    vecs[2].b = '{'{8'd9, 8'd9}, '{8'd9, 8'd9}};
    vecs[2].c = '{'{16'd0, 16'd0}, '{16'd0, 16'd0}};
    vecs[3].a = '{'{8'd1, 8'd1}, '{8'd1, 8'd1}};
    vecs[3].b = '{'{8'd2, 8'd3}, '{8'd4, 8'd5}};
    vecs[3].c = '{'{16'd6, 16'd8}, '{16'd6, 16'd8}};

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_a_out", 64'(bus.A_out), 64'd0);
    check("rst_b_out", 64'(bus.B_out), 64'd0);
    check("rst_streaming", 64'(bus.streaming), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      base = done_cnt;
      load_block(vecs[v], 1'b0, 0);
      wait_done(base);
      check_c(vecs[v], $sformatf("table%0d", v));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end

    // in_valid held through STREAM/DRAIN; the next block waits for done
    base = done_cnt;
    load_block(vecs[1], 1'b1, 0);
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_streaming", 64'(bus.streaming), 64'd1);
    load_block(vecs[3], 1'b0, 0);
    check("bp_first_done", 64'(done_cnt), 64'(base + 1));
    wait_done(base + 1);
    check_c(vecs[3], "bp");

    base = done_cnt;
    load_block(vecs[0], 1'b0, 2);
    check("gap_stream_start", 64'(bus.streaming), 64'd1);
    check("gap_t0_a", 64'(bus.A_out), 64'h0001);
    wait_done(base);
    check_c(vecs[0], "gap");

    base = done_cnt;
    load_block(vecs[3], 1'b0, 0);
    @(posedge clk); #1;
    check("flush_at_t1", 64'(bus.streaming), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_a_zero", 64'(bus.A_out), 64'd0);
    check("flush_b_zero", 64'(bus.B_out), 64'd0);
    check("flush_streaming", 64'(bus.streaming), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("flush_no_done", 64'(done_cnt), 64'(base));
    base = done_cnt;
    load_block(vecs[1], 1'b0, 0);
    wait_done(base);
    check_c(vecs[1], "post_flush");

    base = done_cnt;
    load_block(vecs[0], 1'b0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("drain_ready_low", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("async_in_ready", 64'(bus.in_ready), 64'd1);
    check("async_streaming", 64'(bus.streaming), 64'd0);
    check("async_outputs", 64'({bus.A_out, bus.B_out}), 64'd0);
    check("async_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_no_done", 64'(done_cnt), 64'(base));

    // N=4, no drain, identity B
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        a4[i][k] = operand_t'(i * 4 + k + 1);
    bus4.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        bus4.in_a_col[i] = a4[i][k];
        bus4.in_b_row[i] = (i == k) ? 8'd1 : 8'd0;
      end
      check("n4_ready", 64'(bus4.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    s_cnt    = 0;
    first_nz = -1;
    done_idx = -1;
    for (int c = 0; c < 12; c++) begin
      ha4[c] = 32'(bus4.A_out);
      hb4[c] = 32'(bus4.B_out);
      if (bus4.streaming) s_cnt++;
      if (first_nz < 0 && bus4.A_out[3] != 8'd0) first_nz = c;
      if (bus4.done) done_idx = c;
      @(posedge clk); #1;
    end
    check("n4_stream_cycles", 64'(s_cnt), 64'd7);
    check("n4_lane3_first", 64'(first_nz), 64'd3);
    check("n4_done_idx", 64'(done_idx), 64'd7);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("n4_c%0d%0d", i, j), 64'(arr_c(1'b1, i, j, 12)), 64'(a4[i][j]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
